oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sequences the 256-byte sprite DMA ($4014 write) from CPU address space into primary OAM.
- Halts the CPU for the duration of the transfer, using the CPU memory read port.
- Shares the OAM write port with the sprite evaluator, which reads primary OAM during rendering.
- Sits between the CPU bus interface and the OAM RAM write port, alongside the sprite evaluation block.

Parameters:
- XFER_LEN, 256, number of bytes per transfer; the bench may shorten it. Legal range 1..256.

Ports:
- clk  input  1  master clock
- rst_n  input  1  asynchronous reset, active low
- cpu_clk_en  input  1  CPU-cycle enable; all state advances only when high
- dma_start  input  1  one-cycle strobe of a CPU write to $4014
- dma_page  input  8  source page, sampled with dma_start
- oam_base  input  8  current OAMADDR, sampled with dma_start
- oam_busy  input  1  sprite evaluator owns OAM this cycle; DMA writes must wait
- cpu_rdy  output  1  low halts the CPU
- mem_addr  output  16  CPU-space read address
- mem_re  output  1  read strobe
- mem_rdata  input  8  read data, valid on the cpu_clk_en cycle after mem_re
- oam_wr  output  1  OAM write strobe
- oam_wr_addr  output  8  OAM write address
- oam_wr_data  output  8  OAM write data
- dma_busy  output  1  high from the accepted start until the last write
- dma_done  output  1  one-cpu-cycle pulse after the last write

Behaviour:
- Reset values:
  - state IDLE
  - cpu_rdy=1
  - mem_re=0, oam_wr=0, dma_done=0, dma_busy=0
  - mem_addr=0, oam_wr_addr=0, oam_wr_data=0
  - parity=0, idx=0
- parity: a free-running bit that toggles on every cpu_clk_en.
- idx: 9-bit byte counter.
- States and transitions (all advance on cpu_clk_en only):
  - IDLE: on dma_start, latch page and base, clear idx, go to HALT. dma_start is ignored in every other state.
  - HALT: one cycle. Next state is ALIGN if parity==1, otherwise READ.
  - ALIGN: one dummy cycle, no bus activity, then READ.
  - READ: mem_re=1, mem_addr={page, idx[7:0]}. Go to WRITE.
  - WRITE: capture mem_rdata into a data register.
    - If oam_busy=0: oam_wr=1, oam_wr_addr=base+idx[7:0] (8-bit wrap), oam_wr_data=data register, idx++.
      - If the new idx==XFER_LEN, go to DONE.
      - Otherwise go to READ.
    - If oam_busy=1: go to STALL.
  - STALL: hold the data register; no mem_re, no oam_wr. Stay while oam_busy=1. When oam_busy=0, perform the WRITE action this cycle and take the same next-state decision as WRITE.
  - DONE: dma_done=1 for one cycle, cpu_rdy returns to 1, go to IDLE.
- Output timing:
  - cpu_rdy=0 and dma_busy=1 in HALT, ALIGN, READ, WRITE and STALL.
  - oam_wr and mem_re are combinational decodes of the state, so each is high for exactly one cpu_clk_en period per beat.
  - Outputs hold their values while cpu_clk_en is low.
- Total halt length with no stalls: 2*XFER_LEN+1 cycles if parity was 0 in HALT, or 2*XFER_LEN+2 if parity was 1.
- A stall never drops or duplicates a byte. The captured read data is the value written.
- OAM address wrap: base=0xF0 writes addresses F0..FF, then 00..EF.
- dma_start coinciding with the DONE cycle is ignored; a new start is accepted only in IDLE.
- Reset mid-transfer: returns to IDLE immediately. cpu_rdy=1, no further writes.

Optional Feature:
- OAM_DMA_STALL_CNT_EN defined:
  - Adds output stall_cnt [15:0], which counts cpu_clk_en cycles spent in STALL.
  - Cleared on an accepted dma_start and on reset; saturates at 0xFFFF.
  - Holds its value after DONE.
- Undefined: the stall_cnt port and its logic are absent.

Test Plan:
- Basic transfer: page=0x02, base=0x00, parity=0 at HALT, oam_busy=0, memory[0x0200+i]=i^0x5A.
  - OAM[i]=i^0x5A for i=0..255.
  - cpu_rdy low for exactly 513 CPU cycles; one dma_done pulse.
- Odd alignment: same stimulus with parity=1 at HALT.
  - cpu_rdy low for 514 cycles; ALIGN visited once; data identical.
- Base wrap: base=0xF0, memory[0x0300+i]=i, page=0x03.
  - OAM[(0xF0+i)&0xFF]=i; the first write is to 0xF0 and the 17th write is to 0x00.
- Stall: assert oam_busy for 5 cycles across the WRITE of idx=10.
  - Exactly one write of byte 10, delayed by 5 cycles; total halt 518 cycles.
  - With the macro defined, stall_cnt=5.
- Reset and restart: assert rst_n=0 at idx=100.
  - cpu_rdy=1 and oam_wr=0 at once.
  - After release, a new dma_start completes a full, correct transfer.
- Ignored start: pulse dma_start with page=0x07 in mid-transfer.
  - The latched page is unchanged and no second transfer follows.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sprite DMA sequencer: CPU-space page -> primary OAM, halts CPU during copy
// Optional stall counter output enabled by defining OAM_DMA_STALL_CNT_EN.
module oam_dma_ctrl #(
  parameter int XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk_en,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic [7:0]  oam_base,
  input  logic        oam_busy,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        oam_wr,
  output logic [7:0]  oam_wr_addr,
  output logic [7:0]  oam_wr_data,
  output logic        dma_busy,
  output logic        dma_done
`ifdef OAM_DMA_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [8:0] LEN = 9'(XFER_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE, S_STALL, S_DONE
  } state_e;

  state_e      state_q;
  logic        parity_q;
  logic [8:0]  idx_q;
  logic [8:0]  idx_d;
  logic [7:0]  page_q;
  logic [7:0]  base_q;
  logic [7:0]  data_q;
  logic        beat_wr;

  // A beat commits whenever the evaluator leaves OAM free in WRITE or STALL.
  assign beat_wr = ((state_q == S_WRITE) || (state_q == S_STALL)) && !oam_busy;
  assign idx_d   = idx_q + 9'd1;

  assign cpu_rdy     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign dma_busy    = !cpu_rdy;
  assign dma_done    = (state_q == S_DONE);
  assign mem_re      = (state_q == S_READ);
  assign mem_addr    = {page_q, idx_q[7:0]};
  assign oam_wr      = beat_wr;
  assign oam_wr_addr = base_q + idx_q[7:0];
  // Read data arrives during WRITE itself, so forward it; STALL replays the captured copy.
  assign oam_wr_data = (state_q == S_WRITE) ? mem_rdata : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      idx_q    <= 9'd0;
      page_q   <= 8'd0;
      base_q   <= 8'd0;
      data_q   <= 8'd0;
    end else if (cpu_clk_en) begin
      parity_q <= ~parity_q;
      case (state_q)
        S_IDLE: begin
          if (dma_start) begin
            page_q  <= dma_page;
            base_q  <= oam_base;
            idx_q   <= 9'd0;
            state_q <= S_HALT;
          end
        end
        S_HALT:  state_q <= parity_q ? S_ALIGN : S_READ;
        S_ALIGN: state_q <= S_READ;
        S_READ:  state_q <= S_WRITE;
        S_WRITE, S_STALL: begin
          if (state_q == S_WRITE) data_q <= mem_rdata;
          if (!oam_busy) begin
            idx_q   <= idx_d;
            state_q <= (idx_d == LEN) ? S_DONE : S_READ;
          end else begin
            state_q <= S_STALL;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OAM_DMA_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (cpu_clk_en) begin
      if (state_q == S_IDLE && dma_start) begin
        stall_cnt_q <= 16'd0;
      end else if (state_q == S_STALL && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl with randomised CPU clock enable
`timescale 1ns/1ps
module tb_oam_dma_ctrl;
  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = 8'd0;
  logic [7:0]  oam_base = 8'd0;
  logic        oam_busy = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic        cpu_rdy, mem_re, oam_wr, dma_busy, dma_done;
  logic [15:0] mem_addr;
  logic [7:0]  oam_wr_addr, oam_wr_data;
`ifdef OAM_DMA_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] sb_q[$];
  logic [15:0] sb_exp;
  int  halt_cnt, quiet_cnt, done_cnt, wr_cnt, stray_wr;
  logic [7:0] first_addr, addr17;
  logic [7:0] oam_mem [256];
  bit  par_model = 1'b0;
  bit  en_rand = 1'b0;

  oam_dma_ctrl #(.XFER_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_clk_en(cpu_clk_en), .dma_start(dma_start),
    .dma_page(dma_page), .oam_base(oam_base), .oam_busy(oam_busy), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata), .oam_wr(oam_wr),
    .oam_wr_addr(oam_wr_addr), .oam_wr_data(oam_wr_data), .dma_busy(dma_busy),
    .dma_done(dma_done)
`ifdef OAM_DMA_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    cpu_clk_en = en_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    case (a[15:8])
      8'h02:   return a[7:0] ^ 8'h5A;
      8'h03:   return a[7:0];
      default: return a[7:0] ^ a[15:8] ^ 8'hC3;
    endcase
  endfunction

  // Observes each CPU cycle mid-period: scoreboard pops, halt accounting, memory model.
  always @(negedge clk) begin
    if (cpu_clk_en && rst_n) begin
      if (!cpu_rdy) halt_cnt++;
      if (!cpu_rdy && !mem_re && !oam_wr) quiet_cnt++;
      if (dma_done) done_cnt++;
      if (oam_wr) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL oam_wr_unexpected addr=%h data=%h", oam_wr_addr, oam_wr_data);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({oam_wr_addr, oam_wr_data} !== sb_exp) begin
            failures++;
            $display("FAIL oam_write got addr=%h data=%h exp addr=%h data=%h",
                     oam_wr_addr, oam_wr_data, sb_exp[15:8], sb_exp[7:0]);
          end
        end
        if (wr_cnt == 0) first_addr = oam_wr_addr;
        if (wr_cnt == 16) addr17 = oam_wr_addr;
        oam_mem[oam_wr_addr] = oam_wr_data;
        wr_cnt++;
      end
      if (mem_re) mem_rdata = mem_fn(mem_addr);
    end
    if (!rst_n && oam_wr) stray_wr++;
    par_model = !rst_n ? 1'b0 : (cpu_clk_en ? ~par_model : par_model);
  end

  task automatic tick();
    do @(posedge clk); while (!cpu_clk_en);
    #2;
  endtask

  task automatic clear_stats();
    halt_cnt = 0; quiet_cnt = 0; done_cnt = 0; wr_cnt = 0; stray_wr = 0;
    first_addr = 8'hxx; addr17 = 8'hxx;
  endtask

  task automatic start(input logic [7:0] pg, input logic [7:0] base, input bit hp);
    int g = 0;
    while (par_model == hp && g < 4) begin tick(); g++; end
    clear_stats();
    dma_page = pg;
    oam_base = base;
    for (int i = 0; i < N; i++) sb_q.push_back({base + 8'(i), mem_fn({pg, 8'(i)})});
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (done_cnt == 0 && g < 3000) begin tick(); g++; end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout got done=%0d exp=1", name, done_cnt);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    en_rand = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({cpu_rdy, mem_re, oam_wr, dma_busy, dma_done} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {cpu_rdy, mem_re, oam_wr, dma_busy, dma_done});
    end
    checks++;
    if ({mem_addr, oam_wr_addr, oam_wr_data} !== 32'd0) begin
      failures++;
      $display("FAIL reset_buses got=%h exp=0", {mem_addr, oam_wr_addr, oam_wr_data});
    end
`ifdef OAM_DMA_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
    en_rand = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic(input bit hp, input string name);
    start(8'h02, 8'h00, hp);
    wait_done(name);
    checks++;
    if (halt_cnt != 2 * N + 1 + int'(hp)) begin
      failures++;
      $display("FAIL %s_halt got=%0d exp=%0d", name, halt_cnt, 2 * N + 1 + int'(hp));
    end
    checks++;
    if (quiet_cnt != 1 + int'(hp)) begin
      failures++;
      $display("FAIL %s_align got=%0d exp=%0d", name, quiet_cnt, 1 + int'(hp));
    end
    checks++;
    if (done_cnt != 1 || wr_cnt != N || sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_counts got done=%0d wr=%0d left=%0d exp done=1 wr=%0d left=0",
               name, done_cnt, wr_cnt, sb_q.size(), N);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (oam_mem[i] !== (8'(i) ^ 8'h5A)) begin
        failures++;
        $display("FAIL %s_oam[%0d] got=%h exp=%h", name, i, oam_mem[i], 8'(i) ^ 8'h5A);
      end
    end
  endtask

  task automatic test_wrap();
    start(8'h03, 8'hF0, 1'b0);
    wait_done("wrap");
    checks++;
    if (first_addr !== 8'hF0 || addr17 !== 8'h00) begin
      failures++;
      $display("FAIL wrap_addr got first=%h w17=%h exp first=f0 w17=00", first_addr, addr17);
    end
    checks++;
    if (oam_mem[8'hEF] !== 8'hFF || oam_mem[8'h00] !== 8'h10) begin
      failures++;
      $display("FAIL wrap_data got ef=%h 00=%h exp ef=ff 00=10", oam_mem[8'hEF], oam_mem[8'h00]);
    end
  endtask

  task automatic test_stall();
    int g = 0;
    start(8'h02, 8'h00, 1'b0);
    while (!(mem_re && mem_addr[7:0] == 8'd10) && g < 200) begin tick(); g++; end
    tick();
    oam_busy = 1'b1;
    repeat (5) tick();
    oam_busy = 1'b0;
    wait_done("stall");
    checks++;
    if (halt_cnt != 2 * N + 1 + 5) begin
      failures++;
      $display("FAIL stall_halt got=%0d exp=%0d", halt_cnt, 2 * N + 6);
    end
    checks++;
    if (quiet_cnt != 6 || wr_cnt != N || sb_q.size() != 0) begin
      failures++;
      $display("FAIL stall_counts got quiet=%0d wr=%0d left=%0d exp quiet=6 wr=%0d left=0",
               quiet_cnt, wr_cnt, sb_q.size(), N);
    end
`ifdef OAM_DMA_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd5) begin
      failures++;
      $display("FAIL stall_cnt got=%0d exp=5", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_restart();
    int g = 0;
    start(8'h02, 8'h00, 1'b0);
    while (wr_cnt < 100 && g < 600) begin tick(); g++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_rdy, oam_wr, mem_re, dma_busy} !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_flags got=%b exp=1000", {cpu_rdy, oam_wr, mem_re, dma_busy});
    end
    sb_q.delete();
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    checks++;
    if (stray_wr != 0) begin
      failures++;
      $display("FAIL midreset_stray got=%0d exp=0", stray_wr);
    end
    repeat (3) tick();
    start(8'h04, 8'h10, 1'b1);
    wait_done("restart");
    checks++;
    if (halt_cnt != 2 * N + 2 || wr_cnt != N || done_cnt != 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL restart_counts got halt=%0d wr=%0d done=%0d left=%0d exp halt=%0d wr=%0d done=1 left=0",
               halt_cnt, wr_cnt, done_cnt, sb_q.size(), 2 * N + 2, N);
    end
  endtask

  task automatic test_ignored_start();
    int g = 0;
    start(8'h02, 8'h00, 1'b0);
    repeat (50) tick();
    dma_page = 8'h07;
    oam_base = 8'h33;
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    while (!dma_done && g < 3000) begin tick(); g++; end
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    repeat (20) tick();
    checks++;
    if (halt_cnt != 2 * N + 1 || done_cnt != 1 || wr_cnt != N || sb_q.size() != 0) begin
      failures++;
      $display("FAIL ignored_counts got halt=%0d done=%0d wr=%0d left=%0d exp halt=%0d done=1 wr=%0d left=0",
               halt_cnt, done_cnt, wr_cnt, sb_q.size(), 2 * N + 1, N);
    end
    checks++;
    if (cpu_rdy !== 1'b1 || mem_addr[15:8] !== 8'h02) begin
      failures++;
      $display("FAIL ignored_state got rdy=%b page=%h exp rdy=1 page=02", cpu_rdy, mem_addr[15:8]);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic(1'b0, "basic");
    test_basic(1'b1, "odd");
    test_wrap();
    test_stall();
    test_reset_restart();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
